// File: rtl/aesl_deadlock_proc_monitor.sv
// Per-process deadlock monitor: counts cycles of mutual blocking with peers,
// raises dl_detect_out once a threshold is hit, then joins the token circle.
//
// Ports:
//   clock, reset       rising-edge clock, async active-low reset
//   proc_blocked       this process is stalled on some channel
//   dep_chan_vec       bit i: blocked on the channel shared with peer i
//   dep_blocked_vec    bit i: peer i is itself blocked
//   report_active      report unit has latched a deadlock
//   origin             pulse: this process starts the current circle
//   token_in           token forwarded from some peer
//   token_clear        report unit closes the current circle
//   dl_detect_out      this process's deadlock / circle-member flag
//   token_out_vec      one-hot token forwarded to a peer
//   blk_cycles         current stall-counter value
module aesl_deadlock_proc_monitor #(
    parameter int DEP_NUM   = 2,
    parameter int THRESHOLD = 16,
    parameter int CNT_W     = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               proc_blocked,
    input  logic [DEP_NUM-1:0] dep_chan_vec,
    input  logic [DEP_NUM-1:0] dep_blocked_vec,
    input  logic               report_active,
    input  logic               origin,
    input  logic               token_in,
    input  logic               token_clear,
    output logic               dl_detect_out,
    output logic [DEP_NUM-1:0] token_out_vec,
    output logic [CNT_W-1:0]   blk_cycles
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WATCH = 3'd1;
    localparam logic [2:0] DL    = 3'd2;
    localparam logic [2:0] WAIT  = 3'd3;
    localparam logic [2:0] TOKEN = 3'd4;

    localparam logic [CNT_W-1:0] THR    = CNT_W'(THRESHOLD);
    localparam logic [CNT_W-1:0] THR_M1 = CNT_W'(THRESHOLD - 1);

    logic [2:0]         state;
    logic [2:0]         state_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [DEP_NUM-1:0] fwd_sel;
    logic [DEP_NUM-1:0] mutual;
    logic [DEP_NUM-1:0] low_bit;
    logic               stall_cond;
    logic               tok_req;

    assign mutual     = dep_chan_vec & dep_blocked_vec;
    assign stall_cond = proc_blocked & (|mutual);
    assign tok_req    = origin | token_in;

    // Isolate the lowest set bit: x & -x.
    assign low_bit = mutual & (~mutual + DEP_NUM'(1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = blk_cycles;
        case (state)
            IDLE: begin
                if (stall_cond) begin
                    state_nxt = WATCH;
                    cnt_nxt   = (blk_cycles == THR) ? blk_cycles
                                                    : blk_cycles + 1'b1;
                end else begin
                    cnt_nxt = '0;
                end
            end
            WATCH: begin
                if (!stall_cond) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    // >= keeps THRESHOLD=1 reachable (counter is already 1).
                    if (blk_cycles >= THR_M1)
                        state_nxt = DL;
                    cnt_nxt = (blk_cycles == THR) ? blk_cycles
                                                  : blk_cycles + 1'b1;
                end
            end
            DL: begin
                if (report_active)
                    state_nxt = tok_req ? TOKEN : WAIT;
            end
            WAIT: begin
                if (tok_req)
                    state_nxt = TOKEN;
            end
            TOKEN: begin
                state_nxt = WAIT;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            blk_cycles <= '0;
            fwd_sel    <= '0;
        end else begin
            state      <= state_nxt;
            blk_cycles <= cnt_nxt;
            // TOKEN never follows TOKEN, so this fires only on entry.
            if (state_nxt == TOKEN)
                fwd_sel <= low_bit;
        end
    end

    assign dl_detect_out = ((state == DL) & ~report_active) |
                           (state == TOKEN);

    assign token_out_vec = ((state == TOKEN) & ~token_clear) ? fwd_sel
                                                             : '0;

endmodule

// File: tb/tb_aesl_deadlock_proc_monitor.sv
// Self-checking bench for aesl_deadlock_proc_monitor (THRESHOLD=4, DEP_NUM=2).
// Vector table plus hand sequences; expectations flow through a queue.
module tb_aesl_deadlock_proc_monitor;

    logic       clock;
    logic       reset;
    logic       proc_blocked;
    logic [1:0] dep_chan_vec;
    logic [1:0] dep_blocked_vec;
    logic       report_active;
    logic       origin;
    logic       token_in;
    logic       token_clear;
    logic       dl_detect_out;
    logic [1:0] token_out_vec;
    logic [7:0] blk_cycles;

    aesl_deadlock_proc_monitor #(
        .DEP_NUM(2),
        .THRESHOLD(4),
        .CNT_W(8)
    ) dut (
        .clock(clock),
        .reset(reset),
        .proc_blocked(proc_blocked),
        .dep_chan_vec(dep_chan_vec),
        .dep_blocked_vec(dep_blocked_vec),
        .report_active(report_active),
        .origin(origin),
        .token_in(token_in),
        .token_clear(token_clear),
        .dl_detect_out(dl_detect_out),
        .token_out_vec(token_out_vec),
        .blk_cycles(blk_cycles)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic       pb;
        logic [1:0] ch;
        logic [1:0] db;
        logic       ra;
        logic       org;
        logic       tin;
        logic       tclr;
        logic       edl;
        logic [1:0] etok;
        logic [7:0] ecnt;
    } vec_t;

    typedef struct {
        string      name;
        logic       dl;
        logic [1:0] tok;
        logic [7:0] cnt;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[22];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(string nm, logic pb, logic [1:0] ch,
                                logic [1:0] db, logic ra, logic org,
                                logic tin, logic tclr, logic edl,
                                logic [1:0] etok, logic [7:0] ecnt);
        vec_t v;
        v.name = nm; v.pb = pb; v.ch = ch; v.db = db; v.ra = ra;
        v.org = org; v.tin = tin; v.tclr = tclr;
        v.edl = edl; v.etok = etok; v.ecnt = ecnt;
        return v;
    endfunction

    task automatic cmp(string nm, logic [7:0] act, logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_outs(string nm, logic dl, logic [1:0] tok,
                              logic [7:0] cnt);
        cmp({nm, ".dl"}, {7'd0, dl_detect_out}, {7'd0, dl});
        cmp({nm, ".tok"}, {6'd0, token_out_vec}, {6'd0, tok});
        cmp({nm, ".cnt"}, blk_cycles, cnt);
    endtask

    task automatic apply(vec_t v);
        proc_blocked    = v.pb;
        dep_chan_vec    = v.ch;
        dep_blocked_vec = v.db;
        report_active   = v.ra;
        origin          = v.org;
        token_in        = v.tin;
        token_clear     = v.tclr;
    endtask

    // One cycle: drive after the edge, push expectation, compare at negedge.
    task automatic step(vec_t v);
        exp_t e;
        @(posedge clock);
        #2;
        apply(v);
        e.name = v.name; e.dl = v.edl; e.tok = v.etok; e.cnt = v.ecnt;
        sb.push_back(e);
        @(negedge clock);
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: scoreboard empty", v.name);
        end else begin
            e = sb.pop_front();
            check_outs(e.name, e.dl, e.tok, e.cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t idle;
        //            name        pb ch     db     ra org tin clr  dl tok    cnt
        vecs[0]  = mk("stall0",   1, 2'b01, 2'b01, 0, 0, 0, 0,   0, 2'b00, 0);
        vecs[1]  = mk("stall1",   1, 2'b01, 2'b01, 0, 0, 0, 0,   0, 2'b00, 1);
        vecs[2]  = mk("unblk",    1, 2'b01, 2'b00, 0, 0, 0, 0,   0, 2'b00, 2);
        vecs[3]  = mk("idle_ign", 0, 2'b00, 2'b00, 0, 1, 1, 0,   0, 2'b00, 0);
        vecs[4]  = mk("st_a",     1, 2'b01, 2'b01, 0, 0, 0, 0,   0, 2'b00, 0);
        vecs[5]  = mk("st_b",     1, 2'b01, 2'b01, 0, 0, 1, 0,   0, 2'b00, 1);
        vecs[6]  = mk("st_c",     1, 2'b01, 2'b01, 0, 0, 0, 0,   0, 2'b00, 2);
        vecs[7]  = mk("st_d",     1, 2'b01, 2'b01, 0, 0, 0, 0,   0, 2'b00, 3);
        vecs[8]  = mk("dl_on",    1, 2'b01, 2'b01, 0, 0, 0, 0,   1, 2'b00, 4);
        vecs[9]  = mk("dl_stick", 0, 2'b00, 2'b00, 0, 0, 0, 0,   1, 2'b00, 4);
        vecs[10] = mk("dl_ra_org",0, 2'b11, 2'b11, 1, 1, 0, 0,   0, 2'b00, 4);
        vecs[11] = mk("tok_a",    0, 2'b11, 2'b11, 1, 0, 0, 0,   1, 2'b01, 4);
        vecs[12] = mk("wait_a",   0, 2'b00, 2'b00, 1, 0, 0, 0,   0, 2'b00, 4);
        vecs[13] = mk("wait_tin", 1, 2'b10, 2'b10, 1, 0, 1, 0,   0, 2'b00, 4);
        vecs[14] = mk("tok_clr",  0, 2'b00, 2'b00, 1, 0, 0, 1,   1, 2'b00, 4);
        vecs[15] = mk("wait_b",   0, 2'b00, 2'b00, 1, 0, 0, 0,   0, 2'b00, 4);
        vecs[16] = mk("both",     0, 2'b11, 2'b10, 1, 1, 1, 0,   0, 2'b00, 4);
        vecs[17] = mk("tok_b",    0, 2'b00, 2'b00, 1, 0, 0, 0,   1, 2'b10, 4);
        vecs[18] = mk("wait_c",   0, 2'b00, 2'b00, 1, 0, 0, 0,   0, 2'b00, 4);
        vecs[19] = mk("tin_none", 0, 2'b00, 2'b00, 1, 0, 1, 0,   0, 2'b00, 4);
        vecs[20] = mk("tok_none", 0, 2'b00, 2'b00, 1, 0, 0, 0,   1, 2'b00, 4);
        vecs[21] = mk("wait_d",   0, 2'b00, 2'b00, 0, 0, 0, 0,   0, 2'b00, 4);

        idle = mk("idle", 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0);
        apply(idle);
        reset = 1'b0;
        #12;
        check_outs("reset", 1'b0, 2'b00, 8'd0);
        #10;
        reset = 1'b1;

        for (int i = 0; i < 22; i++)
            step(vecs[i]);

        // Async reset in the middle of a TOKEN cycle.
        step(mk("w2t", 0, 2'b01, 2'b01, 0, 0, 1, 0, 0, 2'b00, 4));
        @(posedge clock);
        #2;
        apply(idle);
        check_outs("tok_pre_rst", 1'b1, 2'b01, 8'd4);
        #1;
        reset = 1'b0;
        #1;
        check_outs("tok_async_rst", 1'b0, 2'b00, 8'd0);
        #2;
        reset = 1'b1;

        // After release: IDLE, tokens ignored, counting restarts from 0.
        step(mk("post_ign", 0, 2'b00, 2'b00, 0, 1, 1, 0, 0, 2'b00, 0));
        step(mk("post_idle",0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));
        step(mk("post_st0", 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 2'b00, 0));
        step(mk("post_st1", 1, 2'b10, 2'b10, 0, 0, 0, 0, 0, 2'b00, 1));
        step(mk("post_drop",0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 2));
        step(mk("post_clr", 0, 2'b00, 2'b00, 0, 0, 0, 0, 0, 2'b00, 0));

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_drain: %0d left expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aesl_deadlock_proc_monitor.md
AESL_DEADLOCK_PROC_MONITOR -- requirements
Module: aesl_deadlock_proc_monitor

Interface
REQ-001 Parameter: DEP_NUM, default 2, number of peer processes this process shares channels with.
REQ-002 Parameter: THRESHOLD, default 16, consecutive mutually-blocked cycles before deadlock is declared; SHALL satisfy 1 <= THRESHOLD <= 2^CNT_W-1.
REQ-003 Parameter: CNT_W, default 8, width of the stall counter.
REQ-004 Port: clock  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  asynchronous, active-low reset.
REQ-006 Port: proc_blocked  input  1  process stalled on any channel (OR of ~blk_n).
REQ-007 Port: dep_chan_vec  input  DEP_NUM  bit i = this process is blocked on the channel shared with peer i.
REQ-008 Port: dep_blocked_vec  input  DEP_NUM  bit i = peer i is itself blocked.
REQ-009 Port: report_active  input  1  report unit has latched a deadlock (its dl_detect_out).
REQ-010 Port: origin  input  1  one-cycle pulse: this process starts the current circle.
REQ-011 Port: token_in  input  1  OR of tokens forwarded to this process by peers.
REQ-012 Port: token_clear  input  1  report unit closes the current circle.
REQ-013 Port: dl_detect_out  output  1  drives this process's bit of the report unit's dl_in_vec.
REQ-014 Port: token_out_vec  output  DEP_NUM  one-hot token forwarded to a peer.
REQ-015 Port: blk_cycles  output  CNT_W  current stall-counter value.

Function
REQ-016 stall_cond SHALL be proc_blocked & |(dep_chan_vec & dep_blocked_vec).
REQ-017 FSM states SHALL be IDLE, WATCH, DL, WAIT, TOKEN; all transitions occur on the rising clock edge.
REQ-018 IDLE: stall_cond=1 -> WATCH; else stay.
REQ-019 WATCH: stall_cond=0 -> IDLE; stall_cond=1 with blk_cycles == THRESHOLD-1 -> DL; else stay.
REQ-020 blk_cycles SHALL increment by 1 each cycle stall_cond=1 in IDLE/WATCH, clear to 0 when stall_cond=0 in those states, saturate at THRESHOLD, and hold in DL/WAIT/TOKEN.
REQ-021 DL: dl_detect_out=1 while report_active=0; report_active=1 -> WAIT.
REQ-022 Once in DL, WAIT or TOKEN, deadlock is sticky: stall_cond deassertion SHALL NOT leave these states; only reset exits.
REQ-023 WAIT: dl_detect_out=0; origin=1 or token_in=1 -> TOKEN; simultaneous origin and token_in -> single TOKEN entry.
REQ-024 DL with report_active=1 and origin=1 or token_in=1 in the same cycle -> TOKEN.
REQ-025 On TOKEN entry, a registered fwd_sel SHALL capture the lowest set bit of (dep_chan_vec & dep_blocked_vec); zero if none set.
REQ-026 TOKEN lasts exactly one cycle: dl_detect_out=1, token_out_vec=fwd_sel, then -> WAIT.
REQ-027 token_out_vec SHALL be 0 in any cycle with token_clear=1, and 0 in every state other than TOKEN.
REQ-028 token_in and origin SHALL be ignored in IDLE and WATCH.
REQ-029 token_clear SHALL not change state; a process in TOKEN returns to WAIT as normal.
REQ-030 Latency: token_in/origin sampled at edge N -> dl_detect_out and token_out_vec valid cycle N+1.

Reset
REQ-031 reset=0 SHALL immediately force IDLE, blk_cycles=0, fwd_sel=0, dl_detect_out=0, token_out_vec=0, independent of clock.
REQ-032 Reset asserted mid-circle (WAIT/TOKEN) SHALL discard any held token; no token_out pulse after reset release until a new TOKEN entry.

Verification
REQ-033 THRESHOLD=4, proc_blocked=1, dep_chan_vec=01, dep_blocked_vec=01 held -> blk_cycles 1,2,3, then DL; dl_detect_out=1 four cycles after stall start.
REQ-034 Stall held 2 cycles then dep_blocked_vec=00 -> return to IDLE, blk_cycles=0, dl_detect_out never asserted.
REQ-035 In DL, report_active=1, origin pulse with dep_chan_vec=11, dep_blocked_vec=11 -> next cycle dl_detect_out=1, token_out_vec=01 for exactly one cycle, then WAIT with both 0.
REQ-036 In WAIT, token_in=1 coincident with token_clear=1 on the TOKEN cycle -> dl_detect_out=1 that cycle, token_out_vec=00.
REQ-037 In DL, drop proc_blocked to 0 -> state stays DL, dl_detect_out stays 1, blk_cycles holds THRESHOLD.
REQ-038 Assert reset=0 asynchronously during TOKEN -> dl_detect_out and token_out_vec go 0 before next clock edge; after release, FSM in IDLE.
